// File: rtl/restaura_mapa_pkg.sv
// Shared encodings for the map-restore block and the datapath that reads the map.
package restaura_mapa_pkg;

   // Restore FSM state codes (also exported on db_estado)
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LEITURA = 2'd1;
   localparam logic [1:0] COPIA   = 2'd2;
   localparam logic [1:0] FIM     = 2'd3;

   // Map cell codes, shared with the collision checker
   localparam logic [1:0] LIVRE     = 2'd0;
   localparam logic [1:0] OBSTACULO = 2'd1;
   localparam logic [1:0] CHEGADA   = 2'd2;

endpackage

// File: rtl/restaura_mapa_contador_celulas.sv
// Cell counter: synchronous up-counter with clear, enable and a terminal flag.
module contador_celulas #(
   parameter int W       = 7,
   parameter int FIM_VAL = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         fim
);

   // Count register; clear has priority over enable
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= q + 1'b1;
      end
   end

   assign fim = (q == W'(FIM_VAL));

endmodule

// File: rtl/restaura_mapa.sv
// Restore responder: copies the selected ROM map into the working-map RAM,
// one cell per cycle, and holds fim_restore until the request is withdrawn.
module restaura_mapa
   import restaura_mapa_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 2,
   parameter int MAPA_W = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     restore,
   input  logic [MAPA_W-1:0]        mapa_sel,
   output logic [MAPA_W+ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0]        rom_data,
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   output logic                     fim_restore,
   output logic                     ocupado,
   output logic [1:0]               db_estado
);

   localparam int N  = 2**ADDR_W;
   // One extra bit so the terminal value N never aliases to cell 0
   localparam int CW = ADDR_W + 1;

   logic [1:0]        estado;
   logic [1:0]        prox;
   logic [MAPA_W-1:0] mapa_q;
   logic [CW-1:0]     k;
   logic              k_fim;
   logic              k_clr;
   logic              k_en;

   // k holds 0 while idle, reaches 1 in LEITURA and runs ahead of the write address by one
   assign k_clr = (estado == IDLE);
   assign k_en  = (estado == LEITURA) || (estado == COPIA);

   contador_celulas #(
      .W       (CW),
      .FIM_VAL (N)
   ) u_contador (
      .clock (clock),
      .reset (reset),
      .clr   (k_clr),
      .en    (k_en),
      .q     (k),
      .fim   (k_fim)
   );

   // Latch the map selector only at the start of a copy
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mapa_q <= '0;
      end else if ((estado == IDLE) && restore) begin
         mapa_q <= mapa_sel;
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= IDLE;
      end else begin
         estado <= prox;
      end
   end

   // Next state: withdrawing restore aborts a copy; FIM waits for restore low
   always_comb begin
      prox = estado;
      case (estado)
         IDLE:    if (restore) prox = LEITURA;
         LEITURA: prox = restore ? COPIA : IDLE;
         COPIA: begin
            if (!restore)  prox = IDLE;
            else if (k_fim) prox = FIM;
         end
         FIM:     if (!restore) prox = IDLE;
         default: prox = IDLE;
      endcase
   end

   // Moore outputs; ROM address leads the RAM address by one cell to cover the read latency
   always_comb begin
      rom_addr    = '0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      fim_restore = 1'b0;
      ocupado     = 1'b0;
      case (estado)
         LEITURA: begin
            rom_addr = {mapa_q, {ADDR_W{1'b0}}};
            ocupado  = 1'b1;
         end
         COPIA: begin
            rom_addr = {mapa_q, k[ADDR_W-1:0]};
            ram_we   = 1'b1;
            ram_addr = k[ADDR_W-1:0] - ADDR_W'(1);
            ocupado  = 1'b1;
         end
         FIM: begin
            fim_restore = 1'b1;
         end
         default: begin
            rom_addr = '0;
         end
      endcase
   end

   assign ram_wdata = rom_data;
   assign db_estado = estado;

endmodule

// File: tb/tb_restaura_mapa.sv
// Bench for restaura_mapa: ROM and RAM models, a latency-based reference model
// checked every cycle, and directed copy / abort / reset scenarios.
module tb_restaura_mapa;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 2;
   localparam int MAPA_W = 2;
   localparam int N      = 2**ADDR_W;

   logic                     clock = 1'b0;
   logic                     reset = 1'b0;
   logic                     restore = 1'b0;
   logic [MAPA_W-1:0]        mapa_sel = '0;
   logic [MAPA_W+ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0]        rom_data = '0;
   logic                     ram_we;
   logic [ADDR_W-1:0]        ram_addr;
   logic [DATA_W-1:0]        ram_wdata;
   logic                     fim_restore;
   logic                     ocupado;
   logic [1:0]               db_estado;

   int n_cmp = 0;
   int n_bad = 0;

   restaura_mapa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAPA_W(MAPA_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .restore     (restore),
      .mapa_sel    (mapa_sel),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .fim_restore (fim_restore),
      .ocupado     (ocupado),
      .db_estado   (db_estado)
   );

   always #5 clock = ~clock;

   // Map image content: every map differs from every other map in every cell
   function automatic logic [DATA_W-1:0] rom_val(input int m, input int c);
      int v;
      v = (c + (c >> 3) + m) % 4;
      return v[DATA_W-1:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Synchronous-read map ROM
   always @(posedge clock) begin
      rom_data <= rom_val(int'(rom_addr[MAPA_W+ADDR_W-1:ADDR_W]), int'(rom_addr[ADDR_W-1:0]));
   end

   // Working RAM sink with per-address write counts
   logic [DATA_W-1:0] ram_img [N];
   int                wr_cnt  [N];
   int                wr_total = 0;
   logic              clr_img = 1'b0;

   always @(posedge clock) begin
      if (clr_img) begin
         for (int i = 0; i < N; i++) begin
            ram_img[i] <= 'x;
            wr_cnt[i]  <= 0;
         end
         wr_total <= 0;
      end else if (ram_we) begin
         ram_img[ram_addr] <= ram_wdata;
         wr_cnt[ram_addr]  <= wr_cnt[ram_addr] + 1;
         wr_total          <= wr_total + 1;
      end
   end

   // Reference model: m_e counts cycles since restore was sampled in idle
   // (m_mode 0 idle, 1 copy in progress, 2 copy complete)
   int           m_mode = 0;
   int           m_e    = 0;
   logic [1:0]   m_map  = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_mode <= 0;
         m_e    <= 0;
      end else begin
         case (m_mode)
            0: if (restore) begin
                  m_mode <= 1;
                  m_e    <= 1;
                  m_map  <= mapa_sel;
               end
            1: if (!restore) m_mode <= 0;
               else if (m_e + 1 == N + 2) m_mode <= 2;
               else m_e <= m_e + 1;
            default: if (!restore) m_mode <= 0;
         endcase
      end
   end

   // Per-cycle comparison of every meaningful output against the model
   always @(negedge clock) begin
      logic             e_we;
      logic [1:0]       e_st;
      logic [ADDR_W-1:0] e_cell;
      logic [ADDR_W-1:0] e_rc;
      e_we   = (m_mode == 1) && (m_e >= 2);
      e_st   = (m_mode == 0) ? 2'd0 : (m_mode == 2) ? 2'd3 : (m_e == 1) ? 2'd1 : 2'd2;
      e_cell = ADDR_W'(m_e - 2);
      e_rc   = ADDR_W'((m_e - 1) % N);
      chk("ram_we", ram_we, e_we);
      chk("ocupado", ocupado, m_mode == 1);
      chk("fim_restore", fim_restore, m_mode == 2);
      chk("db_estado", db_estado, e_st);
      if (e_we) begin
         chk("ram_addr", ram_addr, e_cell);
         chk("ram_wdata", ram_wdata, rom_val(int'(m_map), m_e - 2));
      end
      if (m_mode == 1) chk("rom_addr", rom_addr, {m_map, e_rc});
   end

   task automatic clear_img();
      @(posedge clock); #1 clr_img = 1'b1;
      @(posedge clock); #1 clr_img = 1'b0;
   endtask

   task automatic check_img(input int m);
      int bad;
      bad = 0;
      for (int c = 0; c < N; c++) begin
         chk("ram_img", ram_img[c], rom_val(m, c));
         if (wr_cnt[c] != 1) bad++;
      end
      chk("write_once", bad, 0);
   endtask

   // Waits for fim_restore; returns at a falling edge
   task automatic wait_fim(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (fim_restore) begin
            seen = 1;
            break;
         end
      end
      chk("fim_timeout", seen, 1'b1);
   endtask

   task automatic run_copy(input int m, input bit toggle);
      clear_img();
      @(posedge clock); #1 mapa_sel = MAPA_W'(m); restore = 1'b1;
      if (toggle) begin
         repeat (30) @(posedge clock);
         #1 mapa_sel = MAPA_W'(m + 1);
      end
      wait_fim(200);
      check_img(m);
      @(posedge clock); #1 restore = 1'b0;
      repeat (2) @(posedge clock);
   endtask

   initial begin
      int cyc, first_we, first_fim, nw;
      bit hit;

      // Reset state
      #2;
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_fim", fim_restore, 1'b0);
      chk("rst_ocupado", ocupado, 1'b0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_estado", db_estado, 2'd0);
      #10 reset = 1'b1;

      // Continuous restore on map 2: latency and full copy
      clear_img();
      @(posedge clock); #1 mapa_sel = 2'd2; restore = 1'b1;
      @(posedge clock);
      cyc = 1; first_we = 0; first_fim = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ram_we && first_we == 0) first_we = cyc;
         if (ram_we && ram_addr == 6'd5)  chk("lit_cell5", ram_wdata, 2'd3);
         if (ram_we && ram_addr == 6'd63) chk("lit_cell63", ram_wdata, 2'd0);
         if (fim_restore) begin
            first_fim = cyc;
            break;
         end
         @(posedge clock);
         cyc++;
      end
      chk("first_we_cycle", first_we, 2);
      chk("first_fim_cycle", first_fim, 66);
      check_img(2);

      // Hold in FIM, then withdraw restore
      repeat (10) @(posedge clock);
      #1 restore = 1'b0;
      @(negedge clock);
      chk("fim_held", fim_restore, 1'b1);
      @(posedge clock);
      @(negedge clock);
      chk("fim_drop", fim_restore, 1'b0);
      chk("fim_idle", db_estado, 2'd0);
      chk("no_extra_writes", wr_total, 64);

      // Fresh copies of the other maps, one with a selector change mid-copy
      run_copy(1, 1'b0);
      run_copy(2, 1'b1);
      run_copy(3, 1'b0);
      run_copy(0, 1'b0);

      // Abort after 20 writes
      clear_img();
      @(posedge clock); #1 mapa_sel = 2'd1; restore = 1'b1;
      nw = 0; hit = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ram_we) nw++;
         if (nw == 20) begin
            hit = 1;
            break;
         end
      end
      chk("abort_reach20", hit, 1'b1);
      restore = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("abort_we", ram_we, 1'b0);
      chk("abort_estado", db_estado, 2'd0);
      chk("abort_total", wr_total, 20);
      repeat (5) @(posedge clock);
      @(negedge clock);
      chk("abort_no_fim", fim_restore, 1'b0);

      // Asynchronous reset between clock edges mid-copy
      clear_img();
      @(posedge clock); #1 mapa_sel = 2'd0; restore = 1'b1;
      repeat (10) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("async_we", ram_we, 1'b0);
      chk("async_ocupado", ocupado, 1'b0);
      chk("async_estado", db_estado, 2'd0);
      restore = 1'b0;
      @(posedge clock); #2 reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("post_reset_idle", db_estado, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
